fsm_counter_mc: RTL
===================

Name: fsm_counter_mc

Overview:
- Parametrised, multi-channel successor to the single 3-bit start/stop FSM counter used in the demo designs.
- Provides NCH independent channels, each a start/stop/pause FSM driving a WIDTH-bit counter.
- Each channel has a runtime-selectable wrap or saturate mode and a programmable terminal value.
- Serves as the next demo DUT for miter/invariant checking: per-channel state is exposed on ports.

Parameters:
- WIDTH, 3, counter bit width per channel (>=1).
- NCH, 2, number of independent channels (>=1).

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- start  input  NCH  per-channel start/restart request (level sampled each cycle).
- stop  input  NCH  per-channel stop request.
- pause  input  NCH  per-channel pause, level-sensitive hold.
- mode  input  NCH  per-channel mode: 0 = wrap, 1 = saturate. Latched on the start that enters or re-enters RUN.
- limit  input  NCH*WIDTH  per-channel terminal value; channel i uses bits [i*WIDTH +: WIDTH]. Sampled live every cycle.
- counter  output  NCH*WIDTH  per-channel count, registered.
- state  output  NCH*2  per-channel FSM state, registered: IDLE=00, RUN=01, PAUSE=10, DONE=11.
- wrapped  output  NCH  one-cycle pulse when a wrap-mode channel rolls over.
- done  output  NCH  one-cycle pulse when a saturate-mode channel enters DONE.
- busy  output  1  OR over channels of (state==RUN or state==PAUSE), registered.

Behaviour:
- Reset: all channels go to IDLE; counter, mode latch, wrapped, done and busy are 0.
- rst has priority over every other input.
- Channels are fully independent; channel i uses only bit i / slice i of each vector.
- All outputs are registered. A request sampled at edge k is visible after edge k.
- IDLE:
  - start -> RUN, counter<=0, latch mode.
  - Otherwise hold; counter keeps its last value.
  - stop and pause are ignored.
- RUN, priority stop > start > pause > terminal > increment:
  - stop -> IDLE, counter held.
  - start -> stay RUN, counter<=0, re-latch mode.
  - pause -> PAUSE, counter held.
  - counter >= limit with latched wrap mode -> counter<=0, wrapped pulse.
  - counter >= limit with latched saturate mode -> DONE, counter<=limit, done pulse.
  - Otherwise counter<=counter+1, modulo 2^WIDTH.
- PAUSE:
  - stop -> IDLE, counter held.
  - start -> RUN, counter<=0, re-latch mode.
  - pause still high -> hold.
  - pause low -> RUN, counter held; counting resumes the following cycle.
- DONE:
  - stop -> IDLE, counter held.
  - start -> RUN, counter<=0, re-latch mode.
  - Otherwise hold at limit.
- Terminal comparison uses >=, so lowering limit below the current count terminates on the next RUN cycle instead of running on to 2^WIDTH-1.
- limit=0:
  - wrap mode: counter stays 0 and wrapped pulses every RUN cycle.
  - saturate mode: DONE one cycle after entering RUN.
- limit = 2^WIDTH-1 in wrap mode: full-range counting, rolling over 7->0 when WIDTH=3.
- wrapped and done are 0 except in the single cycle after the qualifying edge.
- wrapped and done never assert while in IDLE or PAUSE.
- Changing mode while in RUN has no effect until the next start.

Test Plan:
- Reset then start[0] for 1 cycle, mode[0]=0, limit0=3 -> counter0 sequence 0,1,2,3,0,1. wrapped[0] is high only in the cycle counter0 becomes 0 after 3. state0=01 throughout.
- mode[1]=1, limit1=5, start[1] pulse -> counter1 0..5, then state1=11 with done[1] high exactly 1 cycle. Counter1 holds 5 for 10 further cycles. A later start[1] restarts at 0.
- Channel 0 in RUN at count 2, pause[0] high 3 cycles -> counter0 holds 2 and state0=10. After pause drops: next cycle state0=01, counter0=2, then 3. Channel 1 is unaffected throughout.
- stop[0] and start[0] asserted in the same RUN cycle -> IDLE with counter held (stop wins). pause+start in PAUSE -> RUN with counter=0.
- Channel 0 RUN at count 6, WIDTH=3, limit0 changed 7->4 -> next cycle counter0=0 with wrapped[0] pulse (wrap mode). In saturate mode the same stimulus gives DONE with counter0=4.
- rst asserted mid-RUN on both channels -> next cycle all states 00, counters 0, busy=0, no done or wrapped pulse.

Source files
------------

// File: rtl/fsm_counter_mc.sv
// NCH independent start/stop/pause FSM counters with per-channel wrap/saturate
// mode and a live terminal value; all outputs registered.
module fsm_counter_mc #(
  parameter int WIDTH = 3,
  parameter int NCH   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       start,
  input  logic [NCH-1:0]       stop,
  input  logic [NCH-1:0]       pause,
  input  logic [NCH-1:0]       mode,
  input  logic [NCH*WIDTH-1:0] limit,
  output logic [NCH*WIDTH-1:0] counter,
  output logic [NCH*2-1:0]     state,
  output logic [NCH-1:0]       wrapped,
  output logic [NCH-1:0]       done,
  output logic                 busy
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;

  logic [NCH-1:0]       mode_q;
  logic [NCH-1:0]       mode_d;
  logic [NCH*WIDTH-1:0] cnt_d;
  logic [NCH*2-1:0]     st_d;
  logic [NCH-1:0]       wrap_d;
  logic [NCH-1:0]       done_d;
  logic                 busy_d;

  always_comb begin
    mode_d = mode_q;
    cnt_d  = counter;
    st_d   = state;
    wrap_d = '0;
    done_d = '0;
    busy_d = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      case (state[i*2 +: 2])
        IDLE: begin
          if (start[i]) begin
            st_d[i*2 +: 2]         = RUN;
            cnt_d[i*WIDTH +: WIDTH] = '0;
            mode_d[i]               = mode[i];
          end
        end
        RUN: begin
          if (stop[i]) begin
            st_d[i*2 +: 2] = IDLE;
          end else if (start[i]) begin
            cnt_d[i*WIDTH +: WIDTH] = '0;
            mode_d[i]               = mode[i];
          end else if (pause[i]) begin
            st_d[i*2 +: 2] = PAUSE;
          end else if (counter[i*WIDTH +: WIDTH] >= limit[i*WIDTH +: WIDTH]) begin
            // >= so a limit lowered below the current count still terminates
            if (mode_q[i]) begin
              st_d[i*2 +: 2]          = DONE;
              cnt_d[i*WIDTH +: WIDTH] = limit[i*WIDTH +: WIDTH];
              done_d[i]               = 1'b1;
            end else begin
              cnt_d[i*WIDTH +: WIDTH] = '0;
              wrap_d[i]               = 1'b1;
            end
          end else begin
            cnt_d[i*WIDTH +: WIDTH] = counter[i*WIDTH +: WIDTH] + 1'b1;
          end
        end
        PAUSE: begin
          if (stop[i]) begin
            st_d[i*2 +: 2] = IDLE;
          end else if (start[i]) begin
            st_d[i*2 +: 2]          = RUN;
            cnt_d[i*WIDTH +: WIDTH] = '0;
            mode_d[i]               = mode[i];
          end else if (!pause[i]) begin
            st_d[i*2 +: 2] = RUN;
          end
        end
        default: begin
          if (stop[i]) begin
            st_d[i*2 +: 2] = IDLE;
          end else if (start[i]) begin
            st_d[i*2 +: 2]          = RUN;
            cnt_d[i*WIDTH +: WIDTH] = '0;
            mode_d[i]               = mode[i];
          end
        end
      endcase
      // busy is derived from next state so it lines up with the registered state
      if (st_d[i*2 +: 2] == RUN || st_d[i*2 +: 2] == PAUSE) begin
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= '0;
      counter <= '0;
      mode_q  <= '0;
      wrapped <= '0;
      done    <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= st_d;
      counter <= cnt_d;
      mode_q  <= mode_d;
      wrapped <= wrap_d;
      done    <= done_d;
      busy    <= busy_d;
    end
  end

endmodule
